// File: rtl/aes128_round_key_generator_if.sv
// rtl/aes128_round_key_generator_if.sv - start/key request and round-key handshake bundle
interface aes128_round_key_generator_if;
  logic [127:0] i_key;
  logic         i_start;
  logic         i_ready;
  logic [127:0] o_round_key;
  logic [3:0]   o_round_index;
  logic         o_valid;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_key, i_start, i_ready,
    input  o_round_key, o_round_index, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_key, i_start, i_ready,
    output o_round_key, o_round_index, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/aes128_round_key_generator.sv
// rtl/aes128_round_key_generator.sv - iterative AES-128 key expansion, one round key per handshake
// Optional macro AES_KEYGEN_SBOX_PIPE_EN registers the SubWord result (adds a SUBW cycle per round).
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv     = gf_inv(byte_val);
  assign sub_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes128_round_key_generator #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 10
) (
  input logic                          i_clock,
  input logic                          i_reset,
  aes128_round_key_generator_if.slave  bus
);
  localparam int KEY_W = NB_BYTE * N_BYTES;

  if (NB_BYTE != 8 || N_BYTES != 16 || N_ROUNDS != 10) begin : g_bad_cfg
    $error("aes128_round_key_generator: only NB_BYTE=8, N_BYTES=16, N_ROUNDS=10 supported");
  end

`ifdef AES_KEYGEN_SBOX_PIPE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, SUBW = 2'd2, DONE = 2'd3} state_t;
  logic [31:0] sub_q;
  logic        capture_sub;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_nxt;
  logic [3:0]       index_q;
  logic [7:0]       rcon_q;
  logic             load_key;
  logic             step_key;
  logic             last_round;
  logic [31:0]      rot_word;
  logic [31:0]      sub_word;
  logic [31:0]      sub_use;
  logic [31:0]      temp;
  logic [31:0]      w0n, w1n, w2n, w3n;

  assign last_round = (index_q == 4'(N_ROUNDS));
  assign rot_word   = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val (rot_word[8*g +: 8]),
      .sub_val  (sub_word[8*g +: 8])
    );
  end

`ifdef AES_KEYGEN_SBOX_PIPE_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)         sub_q <= '0;
    else if (capture_sub) sub_q <= sub_word;
  end
  assign sub_use = sub_q;
`else
  assign sub_use = sub_word;
`endif

  assign temp    = sub_use ^ {rcon_q, 24'h000000};
  assign w0n     = key_q[127:96] ^ temp;
  assign w1n     = key_q[95:64] ^ w0n;
  assign w2n     = key_q[63:32] ^ w1n;
  assign w3n     = key_q[31:0] ^ w2n;
  assign key_nxt = {w0n, w1n, w2n, w3n};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_key  = 1'b0;
    step_key  = 1'b0;
`ifdef AES_KEYGEN_SBOX_PIPE_EN
    capture_sub = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          load_key  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.i_ready) begin
          if (last_round) begin
            state_nxt = DONE;
          end else begin
`ifdef AES_KEYGEN_SBOX_PIPE_EN
            capture_sub = 1'b1;
            state_nxt   = SUBW;
`else
            step_key    = 1'b1;
`endif
          end
        end
      end
`ifdef AES_KEYGEN_SBOX_PIPE_EN
      SUBW: begin
        step_key  = 1'b1;
        state_nxt = EMIT;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      key_q   <= '0;
      index_q <= 4'd0;
      rcon_q  <= 8'h01;
    end else if (load_key) begin
      key_q   <= bus.i_key;
      index_q <= 4'd0;
      rcon_q  <= 8'h01;
    end else if (step_key) begin
      key_q   <= key_nxt;
      index_q <= index_q + 4'd1;
      rcon_q  <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  // Outputs come straight from registers, so async reset clears them immediately.
  assign bus.o_round_key   = key_q;
  assign bus.o_round_index = index_q;
  assign bus.o_valid       = (state == EMIT);
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_done        = (state == DONE);
endmodule

// File: tb/tb_aes128_round_key_generator.sv
// tb/tb_aes128_round_key_generator.sv - randomized self-checking bench against a FIPS-197 word model
module tb_aes128_round_key_generator;
`ifdef AES_KEYGEN_SBOX_PIPE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_keys [11];

  aes128_round_key_generator_if bus ();

  aes128_round_key_generator dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ ({8'h00, a} << i);
    for (int k = 14; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h011b << (k - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
            ^ {rcon_tab[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pulse_start(input logic [127:0] key);
    bus.i_key   = key;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_round_key !== 128'h0 || bus.o_round_index !== 4'd0 || bus.o_valid !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got key=%h idx=%0d v=%b b=%b d=%b want all zero",
               bus.o_round_key, bus.o_round_index, bus.o_valid, bus.o_busy, bus.o_done);
    end
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got v=%b b=%b want 0 0", bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic test_fips_vector;
    logic [127:0] key;
    int bubbles;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(key);
    bus.i_ready = 1'b1;
    pulse_start(key);
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_round_index !== 4'(r) ||
          bus.o_round_key !== exp_keys[r]) begin
        errors++;
        $display("FAIL fips_round%0d got v=%b idx=%0d key=%h want idx=%0d key=%h",
                 r, bus.o_valid, bus.o_round_index, bus.o_round_key, r, exp_keys[r]);
      end
      if (r == 1) begin
        checks++;
        if (bus.o_round_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          errors++;
          $display("FAIL fips_key1 got %h want a0fafe1788542cb123a339392a6c7605", bus.o_round_key);
        end
      end
      if (r == 10) begin
        checks++;
        if (bus.o_round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
          errors++;
          $display("FAIL fips_key10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", bus.o_round_key);
        end
      end
      @(negedge clk);
      if (r < 10) begin
        bubbles = 0;
        while (bus.o_valid !== 1'b1 && bubbles < 5) begin
          bubbles++;
          @(negedge clk);
        end
        checks++;
        if (bubbles != GAP - 1) begin
          errors++;
          $display("FAIL fips_bubbles_r%0d got %0d want %0d", r, bubbles, GAP - 1);
        end
      end
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_cycle got d=%b b=%b v=%b want 1 1 0", bus.o_done, bus.o_busy, bus.o_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_single got d=%b b=%b want 0 0", bus.o_done, bus.o_busy);
    end
  endtask

  task automatic test_zero_key_rcon;
    logic [127:0] got [11];
    logic [7:0] rc;
    int budget;
    model_expand(128'h0);
    bus.i_ready = 1'b1;
    pulse_start(128'h0);
    for (int r = 0; r <= 10; r++) begin
      budget = 0;
      while (bus.o_valid !== 1'b1 && budget < 8) begin
        budget++;
        @(negedge clk);
      end
      got[r] = bus.o_round_key;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_round_index !== 4'(r) || bus.o_round_key !== exp_keys[r]) begin
        errors++;
        $display("FAIL zero_round%0d got v=%b idx=%0d key=%h want %h",
                 r, bus.o_valid, bus.o_round_index, bus.o_round_key, exp_keys[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (got[1] !== 128'h62636363626363636263636362636363) begin
      errors++;
      $display("FAIL zero_key1 got %h want 62636363626363636263636362636363", got[1]);
    end
    for (int r = 1; r <= 10; r++) begin
      rc = got[r][127:120] ^ got[r-1][127:120] ^ sbox_tab[got[r-1][23:16]];
      checks++;
      if (rc !== rcon_tab[r-1]) begin
        errors++;
        $display("FAIL rcon_round%0d got %h want %h", r, rc, rcon_tab[r-1]);
      end
    end
    budget = 0;
    while (bus.o_done !== 1'b1 && budget < 4) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got %b want 1", bus.o_done);
    end
    @(negedge clk);
  endtask

  task automatic test_random_stall;
    logic [127:0] key;
    logic [127:0] held_key;
    logic [3:0]   held_idx;
    bit held;
    bit seen_done;
    int got_n;
    int cyc;
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    bus.i_ready = 1'b0;
    pulse_start(key);
    held = 1'b0;
    seen_done = 1'b0;
    got_n = 0;
    cyc = 0;
    held_key = '0;
    held_idx = '0;
    while (!seen_done && cyc < 300) begin
      if (held) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_round_key !== held_key || bus.o_round_index !== held_idx) begin
          errors++;
          $display("FAIL stall_hold got v=%b idx=%0d key=%h want idx=%0d key=%h",
                   bus.o_valid, bus.o_round_index, bus.o_round_key, held_idx, held_key);
        end
      end
      if (bus.o_done === 1'b1) seen_done = 1'b1;
      bus.i_ready = ($urandom_range(0, 2) != 0);
      held = 1'b0;
      if (bus.o_valid === 1'b1) begin
        if (bus.i_ready) begin
          checks++;
          if (got_n > 10 || bus.o_round_index !== 4'(got_n) || bus.o_round_key !== exp_keys[got_n]) begin
            errors++;
            $display("FAIL stall_accept%0d got idx=%0d key=%h", got_n, bus.o_round_index, bus.o_round_key);
          end
          got_n++;
        end else begin
          held = 1'b1;
          held_key = bus.o_round_key;
          held_idx = bus.o_round_index;
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!seen_done || got_n != 11) begin
      errors++;
      $display("FAIL stall_total got keys=%0d done=%b want 11 1", got_n, seen_done);
    end
    bus.i_ready = 1'b1;
  endtask

  task automatic test_start_ignored;
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] key_c;
    int r;
    int cyc;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    key_c = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_a);
    bus.i_ready = 1'b1;
    pulse_start(key_a);
    r = 0;
    cyc = 0;
    while (bus.o_done !== 1'b1 && cyc < 60) begin
      if (bus.o_valid === 1'b1) begin
        checks++;
        if (r > 10 || bus.o_round_index !== 4'(r) || bus.o_round_key !== exp_keys[r]) begin
          errors++;
          $display("FAIL ignore_emit_r%0d got idx=%0d key=%h", r, bus.o_round_index, bus.o_round_key);
        end
        r++;
      end
      bus.i_start = (r == 3 || r == 4);
      bus.i_key   = key_b;
      @(negedge clk);
      cyc++;
    end
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_done !== 1'b1 || r != 11) begin
      errors++;
      $display("FAIL ignore_sequence got done=%b keys=%0d want 1 11", bus.o_done, r);
    end
    bus.i_start = 1'b1;
    bus.i_key   = key_b;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_start got v=%b d=%b b=%b want 0 0 0", bus.o_valid, bus.o_done, bus.o_busy);
    end
    bus.i_key = key_c;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_round_index !== 4'd0 || bus.o_round_key !== key_c) begin
      errors++;
      $display("FAIL restart_after_done got v=%b idx=%0d key=%h want 1 0 %h",
               bus.o_valid, bus.o_round_index, bus.o_round_key, key_c);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] key;
    int budget;
    int bad;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    bus.i_ready = 1'b1;
    pulse_start(key);
    budget = 0;
    while (!(bus.o_valid === 1'b1 && bus.o_round_index === 4'd5) && budget < 30) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (bus.o_round_index !== 4'd5 || bus.o_round_key !== exp_keys[5]) begin
      errors++;
      $display("FAIL mid_reach5 got idx=%0d key=%h want 5 %h", bus.o_round_index, bus.o_round_key, exp_keys[5]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_round_key !== 128'h0 || bus.o_round_index !== 4'd0 || bus.o_valid !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got key=%h idx=%0d v=%b b=%b d=%b want all zero",
               bus.o_round_key, bus.o_round_index, bus.o_valid, bus.o_busy, bus.o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_mid_reset got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    bus.i_key   = '0;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_zero_key_rcon();
    test_random_stall();
    test_random_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
